// File: rtl/truth_sweep.sv
// rtl/truth_sweep.sv - exhaustive 4-input truth-table sweeper with per-vector settle time
module truth_sweep #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dwell,
  input  logic          e,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          d,
  output logic          busy,
  output logic          smp,
  output logic          done,
  output logic [15:0]   tt,
  output logic [4:0]    ones
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_dwell;
  logic [3:0]    r_vec;
  logic          r_busy;
  logic          r_smp;
  logic          r_done;
  logic [15:0]   r_tt;
  logic [4:0]    r_ones;

  // Sweep sequencer; every output is a register updated together with the state
  // so the drive vector, strobes and results always line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= '0;
      r_dwell <= '0;
      r_vec   <= 4'd0;
      r_busy  <= 1'b0;
      r_smp   <= 1'b0;
      r_done  <= 1'b0;
      r_tt    <= 16'h0000;
      r_ones  <= 5'd0;
    end else begin
      r_smp  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETTLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_dwell <= dwell;
            r_vec   <= 4'd0;
            r_busy  <= 1'b1;
            r_tt    <= 16'h0000;
            r_ones  <= 5'd0;
          end
        end
        S_SETTLE: begin
          // The cycle that sees cnt==dwell is the last settle cycle, giving dwell+1 in total.
          if (r_cnt == r_dwell) begin
            r_state <= S_SAMPLE;
            r_smp   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          r_tt[r_idx] <= e;
          r_ones      <= r_ones + {4'b0000, e};
          // Index 15 ends the sweep instead of incrementing, so idx never wraps.
          if (r_idx == 4'd15) begin
            r_state <= S_DONE;
            r_vec   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_SETTLE;
            r_idx   <= r_idx + 4'd1;
            r_vec   <= r_idx + 4'd1;
            r_cnt   <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign a    = r_vec[3];
  assign b    = r_vec[2];
  assign c    = r_vec[1];
  assign d    = r_vec[0];
  assign busy = r_busy;
  assign smp  = r_smp;
  assign done = r_done;
  assign tt   = r_tt;
  assign ones = r_ones;

endmodule

// File: tb/tb_truth_sweep.sv
// tb/tb_truth_sweep.sv - directed self-checking bench for truth_sweep
module tb_truth_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  dwell;
  logic        e;
  logic        a, b, c, d;
  logic        busy, smp, done;
  logic [15:0] tt;
  logic [4:0]  ones;

  int mode;
  int n_pass  = 0;
  int n_total = 0;

  truth_sweep #(.DW(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dwell (dwell),
    .e     (e),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .busy  (busy),
    .smp   (smp),
    .done  (done),
    .tt    (tt),
    .ones  (ones)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational block under sweep
  always_comb begin
    e = 1'b0;
    case (mode)
      1: e = 1'b1;
      2: e = a & b;
      3: e = a ^ b ^ c ^ d;
      default: e = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that sampled start (edge 0); follows the sweep to its done cycle.
  task automatic watch(input string tag, input int dw, input logic [15:0] exp_tt,
                       input logic [4:0] exp_ones, input bit inject, input bit hold);
    int k = 0;
    int nsmp = 0;
    int good = 0;
    logic [3:0] v;
    while (done !== 1'b1 && k < 16 * (dw + 2) + 20) begin
      tick;
      k++;
      v = {a, b, c, d};
      start = hold | (inject & busy & ((v == 4'd3) | (v == 4'd9)));
      if (inject) dwell = 4'(k);
      if (smp === 1'b1) begin
        if (v == nsmp[3:0] && busy === 1'b1 && k == dw + 1 + nsmp * (dw + 2)) good++;
        nsmp++;
      end
    end
    check({tag, "_done_edge"}, 32'(k), 32'(16 * (dw + 2)));
    check({tag, "_smp_count"}, 32'(nsmp), 32'd16);
    check({tag, "_smp_timing"}, 32'(good), 32'd16);
    check({tag, "_tt"}, 32'(tt), 32'(exp_tt));
    check({tag, "_ones"}, 32'(ones), 32'(exp_ones));
    check({tag, "_done_state"}, 32'({busy, a, b, c, d}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int found;
    int spurious;
    rst   = 1'b1;
    start = 1'b0;
    dwell = 4'd0;
    mode  = 0;
    tick;
    start = 1'b1;
    tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({smp, done}), 32'd0);
    check("rst_tt", 32'(tt), 32'd0);
    check("rst_ones", 32'(ones), 32'd0);
    check("rst_abcd", 32'({a, b, c, d}), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick;
    tick;
    check("idle_wait_busy", 32'(busy), 32'd0);

    // e tied low, dwell 0
    mode = 0; dwell = 4'd0; start = 1'b1;
    tick;
    start = 1'b0;
    check("zero_busy_after_start", 32'(busy), 32'd1);
    watch("zero", 0, 16'h0000, 5'd0, 1'b0, 1'b0);
    tick;
    check("zero_done_one_cycle", 32'(done), 32'd0);

    // e tied high, dwell 3
    mode = 1; dwell = 4'd3; start = 1'b1;
    tick;
    start = 1'b0;
    watch("one", 3, 16'hFFFF, 5'd16, 1'b0, 1'b0);
    tick;
    check("one_done_one_cycle", 32'(done), 32'd0);
    tick;
    check("one_idle_hold_tt", 32'(tt), 32'h0000FFFF);
    check("one_idle_hold_ones", 32'(ones), 32'd16);

    // e = a & b, dwell 1
    mode = 2; dwell = 4'd1; start = 1'b1;
    tick;
    start = 1'b0;
    check("and_tt_cleared", 32'(tt), 32'd0);
    watch("and", 1, 16'hF000, 5'd4, 1'b0, 1'b0);
    tick;

    // parity, dwell 2, stray starts and dwell changes mid-sweep
    mode = 3; dwell = 4'd2; start = 1'b1;
    tick;
    start = 1'b0;
    watch("xor", 2, 16'h6996, 5'd8, 1'b1, 1'b0);
    start = 1'b0;
    tick;
    check("xor_done_one_cycle", 32'(done), 32'd0);

    // reset during settle of vector 7
    mode = 3; dwell = 4'd1; start = 1'b1;
    tick;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      tick;
      if ({a, b, c, d} == 4'd7 && smp === 1'b0 && busy === 1'b1) found = 1;
    end
    check("rst_mid_reached_v7", 32'(found), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tt", 32'(tt), 32'd0);
    check("rst_mid_ones", 32'(ones), 32'd0);
    check("rst_mid_abcd", 32'({a, b, c, d}), 32'd0);
    check("rst_mid_strobes", 32'({smp, done}), 32'd0);
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    check("rst_mid_no_done", 32'(spurious), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    watch("rst_resweep", 1, 16'h6996, 5'd8, 1'b0, 1'b0);
    tick;

    // start held across two sweeps, dwell 0
    mode = 1; dwell = 4'd0; start = 1'b1;
    tick;
    watch("hold1", 0, 16'hFFFF, 5'd16, 1'b0, 1'b1);
    tick;
    check("hold_idle_busy", 32'({busy, done}), 32'd0);
    check("hold_idle_tt", 32'(tt), 32'h0000FFFF);
    mode = 0;
    tick;
    check("hold_restart_busy", 32'(busy), 32'd1);
    check("hold_restart_tt", 32'(tt), 32'd0);
    check("hold_restart_ones", 32'(ones), 32'd0);
    watch("hold2", 0, 16'h0000, 5'd0, 1'b0, 1'b1);
    start = 1'b0;
    tick;
    tick;
    check("hold_end_idle", 32'({busy, done, smp}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
